serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder: loads two operands plus carry-in, then adds one bit per clock,
//  LSB first, through a single 1-bit full-adder cell and a carry flip-flop.
//  Sits downstream of the 1-bit full-adder stage: it consumes that cell's s/co every cycle
//  and turns it into a multi-cycle word adder. Its start/done pair feeds the datapath controller.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; legal range 2..32
// PORTS
//  clk    in   1      rising-edge clock, single clock domain
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request; sampled only in IDLE or DONE
//  a      in   WIDTH  operand A, captured on accepted start
//  b      in   WIDTH  operand B, captured on accepted start
//  ci     in   1      carry-in, captured on accepted start
//  busy   out  1      high while bits are being added
//  done   out  1      one-cycle pulse when sum/co are valid
//  sum    out  WIDTH  result; held stable from done until next accepted start
//  co     out  1      final carry-out; held with sum
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; busy=0, done=0, sum=0, co=0; shift regs, count, carry = 0.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE: start=1 at edge -> load A_r=a, B_r=b, carry=ci, cnt=0, sum=0 (co cleared); go SHIFT.
//  - SHIFT: busy=1. Each edge: cell(A_r[0],B_r[0],carry) -> s,c; sum <= {s,sum[WIDTH-1:1]};
//    carry<=c; A_r,B_r shift right (MSB filled 0); cnt++. When cnt==WIDTH-1 at the edge -> DONE, co<=c.
//  - Exactly WIDTH edges in SHIFT; start ignored there (no queueing, no restart).
//  - DONE: done=1, busy=0 for exactly one cycle. start=1 in DONE is accepted as in IDLE
//    (back-to-back op, done drops, SHIFT next); otherwise -> IDLE.
//  - Latency: start sampled at edge E0 -> busy high E0..E0+WIDTH -> done high in cycle after edge
//    E0+WIDTH; throughput one add per WIDTH+1 cycles.
//  - sum/co: unsigned modulo 2^WIDTH sum plus carry; {co,sum} == a+b+ci exactly.
//  - Intermediate sum visible while busy; consumers use it only when done=1 or later in IDLE.
//  - rst_n low mid-SHIFT: operation aborted, all outputs to reset values, no done pulse.
//  - Inputs a/b/ci may change freely after the start edge; only captured copies are used.
// CONFIGURATION
//  - Macro SERIAL_ADDER_OVF_EN: when defined, adds output port ovf (1 bit): signed two's-complement overflow
//    = carry into MSB XOR carry out of MSB, registered at the last SHIFT edge, held with sum,
//    reset 0, cleared on accepted start.
//  - When undefined: no ovf port, no extra flop; all other behaviour identical.
// STRUCTURE
//  - Package serial_adder_pkg: state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1,
//    ST_DONE=2'd2 (typedef state_t), WIDTH_MAX=32.
//  - Sub-module serial_add_cell: combinational 1-bit full adder, s=a^b^ci, co=ab|aci|bci;
//    one instance, driven by A_r[0], B_r[0], carry.
//  - Top holds FSM, cnt ($clog2(WIDTH) bits), A_r/B_r/sum shift registers, carry flop.
// TESTING
//  - 3+5, ci=0 (WIDTH=8) -> done pulse 9 cycles after start edge, sum=8'h08, co=0.
//  - 8'hFF+8'h01, ci=0 -> sum=8'h00, co=1; 8'hFF+8'hFF, ci=1 -> sum=8'hFF, co=1.
//  - Exhaustive sweep all a,b,ci at WIDTH=4 -> {co,sum}==a+b+ci every op, done single-cycle.
//  - start held high throughout -> ops back-to-back, done every 9 cycles; start pulsed mid-SHIFT ignored.
//  - rst_n low 3 cycles into SHIFT -> busy/done/sum/co immediately 0, FSM IDLE, next op correct.
//  - SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 -> ovf=1, sum=8'h80; 8'hFF+8'h01 -> ovf=0, co=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Used by serial_adder and its cell.
package serial_adder_pkg;

  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_cell.sv
// Combinational 1-bit full adder.
// The single arithmetic cell used by serial_adder.
module serial_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add a signed overflow output (ovf).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic cell_s;
  logic cell_co;

  serial_add_cell u_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
          sum_d   = '0;
          co_d    = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sum_d   = {cell_s, sum_q[WIDTH-1:1]};
        carry_d = cell_co;
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          co_d    = cell_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry into the MSB is the carry feeding this last cell
          ovf_d   = carry_q ^ cell_co;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
